uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one 8N1 UART transmitter (clk/baud counter, 10-bit frame, load on transmit) between N_REQ byte sources.
//  Round-robin grants one byte at a time, drives the transmitter's data/transmit inputs and holds them for the frame.
//  The transmitter has no busy flag, so frame occupancy is timed here by a cycle counter.
//  Sits between on-chip producers (status, debug, host replies) and the single txd pin.
// PARAMETERS
//  N_REQ        4      number of requesters (2..8)
//  CLKS_PER_BIT 10416  clocks per baud period; must equal the transmitter's baud-counter terminal count + 1
//  FRAME_BITS   10     start + 8 data + stop
// PORTS
//  clk          in   1          system clock, all logic on posedge
//  reset        in   1          synchronous, active-high
//  enable       in   1          1 = arbitrate; 0 = no new grants, the current frame completes
//  req_valid    in   N_REQ      requester i has a byte pending; held until its req_ready pulse
//  req_data     in   8*N_REQ    byte of requester i at [8*i+7:8*i]; stable while req_valid[i]
//  req_ready    out  N_REQ      one-hot, single-cycle pulse: byte of requester i accepted
//  tx_data      out  8          to transmitter data; stable for the whole frame window
//  tx_transmit  out  1          to transmitter transmit
//  busy         out  1          1 whenever state != IDLE
//  grant_id     out  $clog2(N_REQ)  index of the last granted requester
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, req_ready=0, tx_transmit=0, tx_data=8'h00, busy=0, grant_id=0, counter=0.
//  All outputs are registered; no combinational path from any input to any output.
//  FSM: IDLE -> LOAD -> FRAME -> IDLE.
//   IDLE : if enable && |req_valid at edge T: pick the first set bit searching from the pointer upward, wrapping N_REQ-1 -> 0.
//          At T: latch tx_data=req_data[i], grant_id=i, pointer=(i+1) mod N_REQ, and set req_ready[i]=1 for cycle T+1 only.
//          Counter=0; go to LOAD.
//   LOAD : tx_transmit=1 for exactly CLKS_PER_BIT cycles, which guarantees the transmitter sees one baud tick while
//          transmit is high. Then tx_transmit=0; go to FRAME.
//   FRAME: wait (FRAME_BITS+1)*CLKS_PER_BIT cycles. The +1 covers the transmitter's one-period state lag. Then go to IDLE.
//  Grant spacing: back-to-back grants are exactly (FRAME_BITS+2)*CLKS_PER_BIT+1 cycles apart, with one IDLE cycle between.
//  tx_data changes only at a grant edge. req_valid and req_data are ignored outside IDLE.
//  A requester dropping req_valid before its grant is legal; no grant is given and no error is raised.
//  All-valid case: grants rotate 0,1,2,3,0,... A lone requester is granted on every slot.
//  enable low while busy: the frame finishes and the FSM returns to IDLE, then stays there until enable goes high.
//  Reset mid-frame: everything returns to reset values the next cycle. The transmitter shares this reset, so no partial frame is resumed.
//  Counter width: $clog2((FRAME_BITS+1)*CLKS_PER_BIT+1) bits. It counts up from 0 and compares against terminal-1; it never wraps.
// STRUCTURE
//  uart_pkg: state encoding (IDLE/LOAD/FRAME), default CLKS_PER_BIT=10416, FRAME_BITS=10.
//  uart_pkg: function frame_clks(cpb, bits)=(bits+1)*cpb.
//  Sub-module rr_arbiter: combinational. Inputs req, ptr. Outputs gnt_onehot, gnt_idx, any.
//  Top: FSM, occupancy counter, data/grant registers.
// TESTING (bench: CLKS_PER_BIT=4, FRAME_BITS=10, N_REQ=4)
//  1. Reset held 3 cycles with req_valid=4'hF -> req_ready=0, tx_transmit=0, busy=0 throughout.
//  2. Single req_valid[2], data 8'hA5, at edge T -> req_ready=4'b0100 in T+1 only; tx_data=8'hA5;
//     tx_transmit high T+1..T+4; busy falls after T+48.
//  3. req_valid=4'hF held, data 8'h10..8'h13 -> grants 0,1,2,3,0 with req_ready pulses exactly 49 cycles apart;
//     tx_data sequence 10,11,12,13,10.
//  4. Pointer at 3, req_valid=4'b0101 -> grant 0 then 2 (wrap); req_valid=4'b1000 only -> repeated grants to 3.
//  5. enable=0 during LOAD -> frame completes, no further req_ready while enable=0;
//     enable=1 -> grant on the next IDLE edge.
//  6. reset pulsed during FRAME -> next cycle busy=0, tx_transmit=0, pointer=0; the pending req_valid[1] is then granted.
//  Checkers: req_ready is onehot0 and 1-cycle wide; tx_data is stable while busy;
//  tx_transmit is never high outside LOAD; back-to-back grant spacing is exactly 49 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter:
//   state_e      arbiter FSM state encoding (idle / load / frame)
//   DefClksPerBit, DefFrameBits  default baud and frame geometry
//   frame_clks() cycles spent waiting out a frame after the load window
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StFrame = 2'd2
    } state_e;

    localparam int unsigned DefClksPerBit = 10416;
    localparam int unsigned DefFrameBits  = 10;

    // One extra bit period covers the transmitter lagging the load by one baud tick.
    function automatic int unsigned frame_clks(input int unsigned cpb, input int unsigned bits);
        return (bits + 1) * cpb;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping from N_REQ-1 back to 0.
// Ports:
//   i_req        request vector
//   i_ptr        highest-priority index for this pick
//   o_gnt_onehot one-hot grant (all zero when no request)
//   o_gnt_idx    index of the granted request
//   o_any        at least one request is set
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IdxW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IdxW-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt_onehot,
    output logic [IdxW-1:0]  o_gnt_idx,
    output logic             o_any
);

    logic [IdxW-1:0] w_idx;

    always_comb begin
        o_gnt_onehot = '0;
        o_gnt_idx    = '0;
        o_any        = 1'b0;
        w_idx        = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            w_idx = IdxW'((32'(i_ptr) + off) % N_REQ);
            if (!o_any && i_req[w_idx]) begin
                o_any               = 1'b1;
                o_gnt_idx           = w_idx;
                o_gnt_onehot[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one 8N1 UART transmitter between N_REQ byte sources. One byte is
// granted at a time (round robin); transmit is held for one baud period so the
// transmitter is guaranteed to see a tick while it is high, then the frame is
// timed out here because the transmitter has no busy flag.
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_enable       1 = arbitrate; 0 = no new grants (current frame completes)
//   i_req_valid    per-requester byte pending
//   i_req_data     byte of requester i at [8*i+7:8*i]
//   o_req_ready    one-hot single-cycle accept pulse
//   o_tx_data      byte to the transmitter, stable for the whole frame window
//   o_tx_transmit  transmitter load strobe (high for CLKS_PER_BIT cycles)
//   o_busy         high whenever the FSM is not idle
//   o_grant_id     index of the most recently granted requester
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
    parameter int unsigned FRAME_BITS   = DefFrameBits,
    localparam int unsigned IdxW        = $clog2(N_REQ)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [8*N_REQ-1:0] i_req_data,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_transmit,
    output logic               o_busy,
    output logic [IdxW-1:0]    o_grant_id
);

    localparam int unsigned FrameClks = frame_clks(CLKS_PER_BIT, FRAME_BITS);
    localparam int unsigned CntW      = $clog2(FrameClks + 1);
    localparam logic [CntW-1:0] LoadLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] FrameLast = CntW'(FrameClks - 1);

    state_e           r_state;
    logic [CntW-1:0]  r_cnt;
    logic [IdxW-1:0]  r_ptr;
    logic [N_REQ-1:0] r_req_ready;
    logic [7:0]       r_tx_data;
    logic             r_tx_transmit;
    logic             r_busy;
    logic [IdxW-1:0]  r_grant_id;

    logic [N_REQ-1:0] w_gnt_onehot;
    logic [IdxW-1:0]  w_gnt_idx;
    logic             w_any;
    logic [7:0]       w_sel_data;
    logic [IdxW-1:0]  w_ptr_next;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .i_req        (i_req_valid),
        .i_ptr        (r_ptr),
        .o_gnt_onehot (w_gnt_onehot),
        .o_gnt_idx    (w_gnt_idx),
        .o_any        (w_any)
    );

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_gnt_onehot[i]) begin
                w_sel_data = i_req_data[8*i +: 8];
            end
        end
    end

    assign w_ptr_next = (w_gnt_idx == IdxW'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_ptr         <= '0;
            r_req_ready   <= '0;
            r_tx_data     <= 8'h00;
            r_tx_transmit <= 1'b0;
            r_busy        <= 1'b0;
            r_grant_id    <= '0;
        end else begin
            r_req_ready <= '0;
            case (r_state)
                StIdle: begin
                    if (i_enable && w_any) begin
                        r_tx_data     <= w_sel_data;
                        r_grant_id    <= w_gnt_idx;
                        r_ptr         <= w_ptr_next;
                        r_req_ready   <= w_gnt_onehot;
                        r_cnt         <= '0;
                        r_tx_transmit <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= StLoad;
                    end
                end
                StLoad: begin
                    if (r_cnt == LoadLast) begin
                        r_cnt         <= '0;
                        r_tx_transmit <= 1'b0;
                        r_state       <= StFrame;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StFrame: begin
                    if (r_cnt == FrameLast) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state       <= StIdle;
                    r_cnt         <= '0;
                    r_tx_transmit <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready   = r_req_ready;
    assign o_tx_data     = r_tx_data;
    assign o_tx_transmit = r_tx_transmit;
    assign o_busy        = r_busy;
    assign o_grant_id    = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter with CLKS_PER_BIT=4, FRAME_BITS=10.
// Inputs are driven 1 ns after the rising edge or on the falling edge; outputs
// are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int unsigned NReq      = 4;
    localparam int unsigned Cpb       = 4;
    localparam int unsigned FrameBits = 10;
    localparam int LoadCyc  = Cpb;                    // cycles tx_transmit is high
    localparam int BusyCyc  = (FrameBits + 2) * Cpb;  // cycles busy is high
    localparam int GrantGap = BusyCyc + 1;            // grant-to-grant spacing

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              enable    = 1'b1;
    logic [NReq-1:0]   req_valid = '0;
    logic [8*NReq-1:0] req_data  = 32'h1312_1110;
    logic [NReq-1:0]   req_ready;
    logic [7:0]        tx_data;
    logic              tx_transmit;
    logic              busy;
    logic [1:0]        grant_id;

    uart_tx_arbiter #(
        .N_REQ        (NReq),
        .CLKS_PER_BIT (Cpb),
        .FRAME_BITS   (FrameBits)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_enable      (enable),
        .i_req_valid   (req_valid),
        .i_req_data    (req_data),
        .o_req_ready   (req_ready),
        .o_tx_data     (tx_data),
        .o_tx_transmit (tx_transmit),
        .o_busy        (busy),
        .o_grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        bit         chk_gap;
    } exp_t;

    typedef struct {
        logic [3:0] valid;
        logic [1:0] exp_id;
        logic [7:0] exp_data;
        bit         chk_gap;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[10];

    int n_checks = 0;
    int n_errors = 0;
    int n_grants = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [7:0] data, input bit chk_gap);
        exp_t e;
        e.id      = id;
        e.data    = data;
        e.chk_gap = chk_gap;
        sb_q.push_back(e);
    endtask

    task automatic set_vec(input int idx, input logic [3:0] valid, input logic [1:0] id,
                           input logic [7:0] data, input bit chk_gap);
        vecs[idx].valid    = valid;
        vecs[idx].exp_id   = id;
        vecs[idx].exp_data = data;
        vecs[idx].chk_gap  = chk_gap;
    endtask

    // Returns on the rising edge after the next grant has been observed.
    task automatic wait_grant(input string name);
        int target;
        bit got;
        target = n_grants + 1;
        got    = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            if (n_grants >= target) begin
                got = 1'b1;
                break;
            end
        end
        check(name, 32'(got), 1);
    endtask

    task automatic wait_idle(input string name);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(name, 32'(busy), 0);
    endtask

    // ---------------------------------------------------------------- monitor
    // Timing model: k counts falling edges since the grant pulse was seen.
    bit         rst_q      = 1'b1;
    bit         active     = 1'b0;
    int         k          = 0;
    int         cyc        = 0;
    int         last_grant = 0;
    logic [3:0] prev_ready = '0;
    logic       prev_busy  = 1'b0;
    logic [7:0] prev_data  = '0;

    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] oh;
        cyc++;
        if (rst_q) begin
            active = 1'b0;
            check("rst_ready", 32'(req_ready), 0);
            check("rst_transmit", 32'(tx_transmit), 0);
            check("rst_busy", 32'(busy), 0);
        end else begin
            if (req_ready != '0) begin
                check("grant_while_busy", 32'(active), 0);
                if (sb_q.size() == 0) begin
                    check("unexpected_grant", 32'(req_ready), 0);
                end else begin
                    e  = sb_q.pop_front();
                    oh = 4'b0001 << e.id;
                    check("sb_ready", 32'(req_ready), 32'(oh));
                    check("sb_grant_id", 32'(grant_id), 32'(e.id));
                    check("sb_tx_data", 32'(tx_data), 32'(e.data));
                    if (e.chk_gap) check("grant_gap", 32'(cyc - last_grant), GrantGap);
                end
                active     = 1'b1;
                k          = 0;
                last_grant = cyc;
                n_grants++;
            end else if (active) begin
                k++;
                if (k >= BusyCyc) active = 1'b0;
            end
            check("transmit_window", 32'(tx_transmit), 32'(active && k < LoadCyc));
            check("busy_window", 32'(busy), 32'(active));
            check("ready_onehot0", 32'($onehot0(req_ready)), 1);
            check("ready_width", 32'(req_ready & prev_ready), 0);
            if (busy && prev_busy) check("data_stable", 32'(tx_data), 32'(prev_data));
        end
        rst_q      = reset;
        prev_ready = req_ready;
        prev_busy  = busy;
        prev_data  = tx_data;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        // ptr is 3 after the single-requester test.
        set_vec(0, 4'b0101, 2'd0, 8'h10, 1'b0);
        set_vec(1, 4'b0101, 2'd2, 8'h12, 1'b1);
        set_vec(2, 4'b1000, 2'd3, 8'h13, 1'b1);
        set_vec(3, 4'b1000, 2'd3, 8'h13, 1'b1);
        set_vec(4, 4'b1000, 2'd3, 8'h13, 1'b1);
        set_vec(5, 4'b1111, 2'd0, 8'h10, 1'b1);
        set_vec(6, 4'b1111, 2'd1, 8'h11, 1'b1);
        set_vec(7, 4'b1111, 2'd2, 8'h12, 1'b1);
        set_vec(8, 4'b1111, 2'd3, 8'h13, 1'b1);
        set_vec(9, 4'b1111, 2'd0, 8'h10, 1'b1);

        // Reset held with every requester valid.
        req_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_ready", 32'(req_ready), 0);
            check("t1_transmit", 32'(tx_transmit), 0);
            check("t1_busy", 32'(busy), 0);
        end
        check("t1_tx_data", 32'(tx_data), 0);
        check("t1_grant_id", 32'(grant_id), 0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = '0;

        // Single requester 2 with a distinct byte; exact frame timing.
        @(negedge clk);
        push_exp(2'd2, 8'hA5, 1'b0);
        req_data[23:16] = 8'hA5;
        req_valid       = 4'b0100;
        for (int kk = 0; kk <= BusyCyc; kk++) begin
            @(negedge clk);
            case (kk)
                0: begin
                    check("t2_ready_pulse", 32'(req_ready), 32'h4);
                    check("t2_tx_data", 32'(tx_data), 32'hA5);
                    check("t2_transmit_first", 32'(tx_transmit), 1);
                    check("t2_grant_id", 32'(grant_id), 2);
                    req_valid       = '0;
                    req_data[23:16] = 8'h12;
                end
                1: check("t2_ready_gone", 32'(req_ready), 0);
                LoadCyc - 1: check("t2_transmit_last", 32'(tx_transmit), 1);
                LoadCyc: check("t2_transmit_off", 32'(tx_transmit), 0);
                BusyCyc - 1: begin
                    check("t2_busy_last", 32'(busy), 1);
                    check("t2_tx_data_hold", 32'(tx_data), 32'hA5);
                end
                BusyCyc: check("t2_busy_off", 32'(busy), 0);
                default: ;
            endcase
        end

        // Table: wrap from pointer 3, lone requester, full rotation.
        for (int i = 0; i < 10; i++) begin
            #1;
            push_exp(vecs[i].exp_id, vecs[i].exp_data, vecs[i].chk_gap);
            req_valid = vecs[i].valid;
            wait_grant("vec_grant");
        end
        #1;
        req_valid = '0;

        // enable dropped during LOAD: frame completes, no grants until re-enabled.
        wait_idle("t5_idle_before");
        push_exp(2'd1, 8'h11, 1'b0);
        req_valid = 4'b0010;
        wait_grant("t5_first_grant");
        #1;
        enable = 1'b0;
        begin
            int g0;
            g0 = n_grants;
            repeat (70) @(posedge clk);
            check("t5_no_grant_disabled", 32'(n_grants), 32'(g0));
        end
        @(negedge clk);
        check("t5_idle_disabled", 32'(busy), 0);
        push_exp(2'd1, 8'h11, 1'b0);
        @(posedge clk);
        #1;
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_grant_after_enable", 32'(req_ready), 32'h2);

        // Reset mid-frame; pointer returns to 0 so requester 1 wins over 2.
        repeat (12) @(posedge clk);
        #1;
        reset     = 1'b1;
        req_valid = 4'b0110;
        push_exp(2'd1, 8'h11, 1'b0);
        push_exp(2'd2, 8'h12, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("t6_busy", 32'(busy), 0);
        check("t6_transmit", 32'(tx_transmit), 0);
        check("t6_tx_data", 32'(tx_data), 0);
        check("t6_grant_id", 32'(grant_id), 0);
        check("t6_ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_grant("t6_first_grant");
        wait_grant("t6_second_grant");
        #1;
        req_valid = '0;
        wait_idle("t6_idle_end");

        check("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
